// File: rtl/decoder_pkg.sv
// Shared types and default timing for the binary decoder driver.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int unsigned DEF_HOLD_CYCLES = 32'd4;
   localparam int unsigned DEF_GAP_CYCLES  = 32'd1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder; all-zero when disabled.
module dec3to8 (
   input  logic       en,
   input  logic [2:0] Y,
   output logic [7:0] O
);

   // One-hot decode gated by enable
   always_comb begin
      O = 8'h00;
      if (en) begin
         O = 8'h01 << Y;
      end else begin
         O = 8'h00;
      end
   end

endmodule

// File: rtl/binary_decoder_driver.sv
// Accepts a 3-bit code, drives its one-hot decode for HOLD_CYCLES cycles,
// then idles for GAP_CYCLES cycles before accepting the next code.
module binary_decoder_driver
   import decoder_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] Y,
   input  logic       valid,
   output logic       ready,
   output logic [7:0] O,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] GAP_LOAD  =
      CNT_W'((GAP_CYCLES == 32'd0) ? 32'd0 : (GAP_CYCLES - 32'd1));

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       y_q, y_d;
   logic [7:0]       o_q, o_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             armed_q, armed_d;
   logic             drive_d;

   // armed_q blocks an accept on the very first edge after reset release
   assign ready = (state_q == IDLE) && en && armed_q;
   assign O     = o_q;
   assign busy  = busy_q;
   assign done  = done_q;

   // Next-state, counter and done-pulse logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      done_d  = 1'b0;
      armed_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (valid && ready) begin
               state_d = DRIVE;
               cnt_d   = HOLD_LOAD;
               y_d     = Y;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         DRIVE: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_ZERO) begin
               done_d = 1'b1;
               if (GAP_CYCLES > 32'd0) begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = CNT_ZERO;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         GAP: begin
            if (!en || (cnt_q == CNT_ZERO)) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
      busy_d  = (state_d != IDLE);
      drive_d = (state_d == DRIVE);
   end

   dec3to8 u_dec (
      .en (drive_d),
      .Y  (y_d),
      .O  (o_d)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
         y_q     <= 3'd0;
         o_q     <= 8'h00;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         o_q     <= o_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: tb/tb_binary_decoder_driver.sv
// Directed self-checking bench: default timing instance plus a GAP_CYCLES=0 instance.
module tb_binary_decoder_driver;

   logic       clk, rst_n;
   logic       en, valid, ready, busy, done;
   logic [2:0] y;
   logic [7:0] o;
   logic       en_b, valid_b, ready_b, busy_b, done_b;
   logic [2:0] y_b;
   logic [7:0] o_b;

   int total = 0;
   int bad   = 0;

   binary_decoder_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .Y(y), .valid(valid),
      .ready(ready), .O(o), .busy(busy), .done(done)
   );

   binary_decoder_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b2b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .Y(y_b), .valid(valid_b),
      .ready(ready_b), .O(o_b), .busy(busy_b), .done(done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 30) begin
         step();
         n++;
      end
      check("ready_wait", 32'(ready), 32'd1);
   endtask

   // One full operation on the default instance; optionally keep offering `other`
   task automatic op(input logic [2:0] code, input bit keep, input logic [2:0] other);
      logic [7:0] exp_o;
      exp_o = 8'h01 << code;
      wait_ready();
      valid = 1'b1;
      y     = code;
      step();
      if (keep) begin
         y = other;
      end else begin
         valid = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         check("hold_o", 32'(o), 32'(exp_o));
         check("hold_done", 32'(done), 32'd0);
         check("hold_busy", 32'(busy), 32'd1);
         step();
      end
      check("done_pulse", 32'(done), 32'd1);
      check("gap_o", 32'(o), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      step();
      check("idle_o", 32'(o), 32'd0);
      check("done_single", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; valid = 1'b0; y = 3'd0;
      en_b = 1'b0; valid_b = 1'b0; y_b = 3'd0;
      #12;
      check("rst_o", 32'(o), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      rst_n = 1'b1;
      step();

      // single decode of 3
      op(3'd3, 1'b0, 3'd0);

      // walk all codes
      for (int c = 0; c < 8; c++) begin
         op(3'(c), 1'b0, 3'd0);
      end

      // offer of 5 held during DRIVE of 2 is ignored, then accepted from IDLE
      op(3'd2, 1'b1, 3'd5);
      step();
      check("late_accept", 32'(o), 32'h20);
      valid = 1'b0;
      wait_ready();

      // abort in 2nd DRIVE cycle of 6
      valid = 1'b1; y = 3'd6;
      step();
      valid = 1'b0;
      check("abort_d1", 32'(o), 32'h40);
      step();
      check("abort_d2", 32'(o), 32'h40);
      en = 1'b0;
      step();
      check("abort_o", 32'(o), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ready_en0", 32'(ready), 32'd0);
      en = 1'b1;
      #1;
      check("abort_idle", 32'(ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_done", 32'(done), 32'd0);
      end

      // asynchronous reset during DRIVE of 7
      valid = 1'b1; y = 3'd7;
      step();
      valid = 1'b0;
      step();
      check("pre_rst_o", 32'(o), 32'h80);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_o", 32'(o), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      valid = 1'b1; y = 3'd7;
      #2 rst_n = 1'b1;
      step();
      check("first_edge_no_accept", 32'(o), 32'd0);
      check("first_edge_busy", 32'(busy), 32'd0);
      check("armed_ready", 32'(ready), 32'd1);
      step();
      check("post_rst_accept", 32'(o), 32'h80);
      valid = 1'b0;
      wait_ready();

      // GAP_CYCLES=0 back-to-back on the second instance
      en_b = 1'b1; valid_b = 1'b1; y_b = 3'd1;
      #1;
      check("b2b_ready0", 32'(ready_b), 32'd1);
      step();
      y_b = 3'd4;
      for (int i = 0; i < 4; i++) begin
         check("b2b_hold1", 32'(o_b), 32'h02);
         step();
      end
      check("b2b_gap_o", 32'(o_b), 32'd0);
      check("b2b_done", 32'(done_b), 32'd1);
      check("b2b_ready", 32'(ready_b), 32'd1);
      check("b2b_busy", 32'(busy_b), 32'd0);
      step();
      check("b2b_hold4", 32'(o_b), 32'h10);
      valid_b = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/binary_decoder_driver.md
BINARY_DECODER_DRIVER -- requirements
Module: binary_decoder_driver

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, number of cycles a decoded one-hot output is driven (legal range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, number of all-zero cycles after each hold (legal range 0..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, block enable; low forbids new accepts and aborts any operation in progress.
REQ-006 SHALL have port Y, input, 3, binary code to decode (0..7).
REQ-007 SHALL have port valid, input, 1, Y is offered this cycle.
REQ-008 SHALL have port ready, output, 1, the block can accept Y this cycle.
REQ-009 SHALL have port O, output, 8, registered one-hot decode of the accepted code.
REQ-010 SHALL have port busy, output, 1, high while in DRIVE or GAP.
REQ-011 SHALL have port done, output, 1, single-cycle pulse marking a completed hold.

Function
REQ-012 SHALL implement the FSM states IDLE, DRIVE and GAP.
REQ-013 SHALL drive ready combinationally as (state==IDLE) && en.
REQ-014 SHALL accept only on a rising edge where valid && ready; it SHALL latch Y at that edge and move to DRIVE.
REQ-015 SHALL drive O = 1<<Y_latched for exactly HOLD_CYCLES cycles, starting the cycle after the accept edge, and O = 8'h00 in every other cycle.
REQ-016 SHALL load the hold counter with HOLD_CYCLES-1 on accept and decrement it once per DRIVE cycle; at 0 it SHALL leave DRIVE.
REQ-017 SHALL move from DRIVE to GAP when GAP_CYCLES>0, otherwise directly to IDLE.
REQ-018 SHALL pulse done high for one cycle, in the first cycle after DRIVE ends, only on normal completion.
REQ-019 SHALL stay in GAP for exactly GAP_CYCLES cycles with O=0, then go to IDLE.
REQ-020 SHALL ignore valid and Y outside IDLE, with no queueing of offers.
REQ-021 SHALL abort when en is low during DRIVE or GAP: next state IDLE, O=0 from the next cycle, counter cleared, no done.
REQ-022 SHALL allow back-to-back operation with GAP_CYCLES=0: ready is high in the cycle after the last DRIVE cycle, giving a minimum accept-to-accept spacing of HOLD_CYCLES+GAP_CYCLES+1 cycles.
REQ-023 SHALL use a counter of width clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); the counter SHALL never wrap below 0.

Reset
REQ-024 SHALL, on rst_n low, immediately and asynchronously set state=IDLE, O=8'h00, done=0, busy=0, counter=0 and Y_latched=0.
REQ-025 SHALL discard any in-progress operation on reset mid-DRIVE or mid-GAP without pulsing done.
REQ-026 SHALL not accept in the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take the FSM state enum and the default HOLD_CYCLES/GAP_CYCLES constants from a shared package, decoder_pkg.
REQ-028 SHALL use one combinational sub-module, dec3to8 (input en, Y[2:0]; output O[7:0]), for the one-hot decode.

Verification
REQ-029 SHALL verify a single decode with HOLD=4, GAP=1: en=1, valid=1, Y=3 for one cycle -> O=8'h08 for 4 cycles, done pulses once, O=0 for 1 gap cycle, then ready=1.
REQ-030 SHALL verify all codes: Y=0..7 sent sequentially -> O walks 8'h01..8'h80, one done per code, no overlap between holds.
REQ-031 SHALL verify ignored input: valid=1 with Y=5 held throughout a DRIVE of Y=2 -> O stays 8'h04; Y=5 is accepted only after return to IDLE.
REQ-032 SHALL verify abort: en dropped in the 2nd DRIVE cycle of Y=6 -> O=0 next cycle, state IDLE, no done pulse.
REQ-033 SHALL verify reset mid-operation: rst_n low during DRIVE of Y=7 -> O=0 immediately, with no clock edge needed; no accept on the first edge after release.
REQ-034 SHALL verify GAP_CYCLES=0 back-to-back: Y=1 then Y=4 offered continuously -> O=8'h02 for HOLD cycles, O=0 for one cycle, then O=8'h10.
